// File: rtl/fifo_serial_pkg.sv
// fifo_serial_pkg
// Shared types and constants for the FIFO-fed serial transmitter.
//   state_t   : transmitter FSM states
//   TXD_IDLE  : line level when idle / stop bit
//   TXD_START : line level of the start bit
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN adds the PARITY state.
package fifo_serial_pkg;

   localparam logic TXD_IDLE  = 1'b1;
   localparam logic TXD_START = 1'b0;

`ifdef FIFO_SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_LOAD, ST_START, ST_DATA, ST_PARITY, ST_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_LOAD, ST_START, ST_DATA, ST_STOP
   } state_t;
`endif

endpackage

// File: rtl/fifo_serial_tx_if.sv
// fifo_serial_tx_if
// Word-FIFO read handshake between the FIFO (master) and its consumer (slave).
//   fifo_val     : FIFO non-empty
//   fifo_dataout : registered FIFO output, valid the cycle after a read
//   fifo_read    : one-cycle pop strobe from the consumer
interface fifo_serial_tx_if #(
   parameter int DATA_W = 10
);
   logic              fifo_val;
   logic [DATA_W-1:0] fifo_dataout;
   logic              fifo_read;

   modport master (output fifo_val, output fifo_dataout, input fifo_read);
   modport slave  (input fifo_val, input fifo_dataout, output fifo_read);
endinterface

// File: rtl/serial_bit_timer.sv
// serial_bit_timer
// Bit-period counter: counts 0..BAUD_DIV-1 while run is high and wraps.
//   clock, reset : clock, async active-high reset
//   clear        : force the count back to 0
//   run          : count enable
//   tick         : high on the terminal count (every cycle when BAUD_DIV=1)
module serial_bit_timer #(
   parameter int BAUD_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (clear)
         r_cnt <= '0;
      else if (run)
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
   end

   assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Pops words from the upstream word FIFO and sends each one LSB-first as an
// asynchronous serial frame: start bit, DATA_W data bits, [even parity], stop.
//   clock, reset : clock, async active-high reset
//   enable       : permits starting a new frame (ignored mid-frame)
//   fifo         : FIFO read handshake (slave side)
//   txd          : serial line, idle high, registered
//   busy         : high whenever the FSM is not IDLE
//   frame_done   : one-cycle pulse in the first IDLE cycle after a stop bit
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (even-parity bit after MSB).
module fifo_serial_tx
   import fifo_serial_pkg::*;
#(
   parameter int DATA_W   = 10,
   parameter int BAUD_DIV = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   fifo_serial_tx_if.slave   fifo,
   output logic              txd,
   output logic              busy,
   output logic              frame_done
);

   localparam int BCW = $clog2(DATA_W) + 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [BCW-1:0]    r_bit_cnt;
   logic              r_txd;
   logic              r_fifo_read;
   logic              r_busy;
   logic              r_frame_done;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic              r_parity;
`endif

   logic w_run;
   logic w_tick;

   // The bit timer only counts while a line bit is being driven; holding it
   // clear through IDLE/FETCH/LOAD aligns the start bit to a full period.
   always_comb begin
      w_run = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
`ifdef FIFO_SERIAL_TX_PARITY_EN
      if (r_state == ST_PARITY) w_run = 1'b1;
`endif
   end

   serial_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_timer (
      .clock (clock),
      .reset (reset),
      .clear (!w_run),
      .run   (w_run),
      .tick  (w_tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_txd        <= TXD_IDLE;
         r_fifo_read  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         r_parity     <= 1'b0;
`endif
      end else begin
         r_fifo_read  <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (enable && fifo.fifo_val) begin
                  r_state     <= ST_FETCH;
                  r_fifo_read <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            // FIFO output is registered: data appears one cycle after the pop.
            ST_FETCH: r_state <= ST_LOAD;
            ST_LOAD: begin
               r_shift   <= fifo.fifo_dataout;
`ifdef FIFO_SERIAL_TX_PARITY_EN
               r_parity  <= ^fifo.fifo_dataout;
`endif
               r_bit_cnt <= '0;
               r_txd     <= TXD_START;
               r_state   <= ST_START;
            end
            ST_START: begin
               if (w_tick) begin
                  r_txd   <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                     r_txd   <= r_parity;
                     r_state <= ST_PARITY;
`else
                     r_txd   <= TXD_IDLE;
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_txd     <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                  end
               end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_txd   <= TXD_IDLE;
                  r_state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign txd            = r_txd;
   assign busy           = r_busy;
   assign frame_done     = r_frame_done;
   assign fifo.fifo_read = r_fifo_read;

endmodule
